// File: rtl/rom_ram_ctrl_pkg.sv
// Shared types and constants for the ROM-to-RAM copy/verify controller.
package rom_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCopy,
        StVerify,
        StDone
    } ctrl_state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;

    // Keeps the tracking pipe at a buildable depth if RD_LAT is set out of range.
    function automatic int unsigned rd_lat_clamp(input int unsigned lat);
        if (lat < RD_LAT_MIN) begin
            return RD_LAT_MIN;
        end
        if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid/index delay line matching the memory read latency, so each returning
// word is tagged with the transfer index that requested it.
module rd_lat_pipe #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    input  logic [IW-1:0] i_idx,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);

    logic [DEPTH-1:0]         r_vld;
    logic [DEPTH-1:0][IW-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_idx <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_idx[0] <= i_idx;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_idx[k] <= r_idx[k-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_idx = r_idx[DEPTH-1];

endmodule

// File: rtl/rom_ram_copy_ctrl.sv
// Copies a ROM block into RAM, reads both back and counts mismatching words.
// Sole master of both single-port memory ports; all outputs are registered.
module rom_ram_copy_ctrl
    import rom_ram_ctrl_pkg::*;
#(
    parameter int unsigned AW     = 8,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] first_err_addr,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q
);

    localparam int unsigned PipeDepth = rd_lat_clamp(RD_LAT);
    localparam logic [AW:0] ErrMax    = {1'b1, {AW{1'b0}}};

    ctrl_state_t   r_state;
    logic          r_busy;
    logic          r_done;
    logic [AW:0]   r_err_cnt;
    logic [AW-1:0] r_first_err;
    logic [AW-1:0] r_rom_addr;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_data;
    logic          r_ram_wren;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [AW:0]   r_len;
    logic          r_iss_vld;
    logic [AW-1:0] r_iss_idx;
    logic [AW-1:0] r_wr_idx;

    logic          w_pipe_vld;
    logic [AW-1:0] w_pipe_idx;
    logic [AW:0]   w_len_m1;
    logic          w_iss_last;
    logic          w_pipe_last;
    logic          w_wr_last;

    // One shared tracker: copy and verify reads never overlap in time.
    rd_lat_pipe #(
        .DEPTH (PipeDepth),
        .IW    (AW)
    ) u_rd_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_vld (r_iss_vld),
        .i_idx (r_iss_idx),
        .o_vld (w_pipe_vld),
        .o_idx (w_pipe_idx)
    );

    assign w_len_m1    = r_len - (AW+1)'(1);
    assign w_iss_last  = ({1'b0, r_iss_idx}  == w_len_m1);
    assign w_pipe_last = ({1'b0, w_pipe_idx} == w_len_m1);
    assign w_wr_last   = ({1'b0, r_wr_idx}   == w_len_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_rom_addr  <= '0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_wren  <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_iss_vld   <= 1'b0;
            r_iss_idx   <= '0;
            r_wr_idx    <= '0;
        end else begin
            r_done     <= 1'b0;
            r_ram_wren <= 1'b0;

            // Address issue: one index per cycle until len-1 has been driven.
            if (r_iss_vld) begin
                if (w_iss_last) begin
                    r_iss_vld <= 1'b0;
                end else begin
                    r_iss_idx  <= r_iss_idx + AW'(1);
                    r_rom_addr <= r_rom_addr + AW'(1);
                    if (r_state == StVerify) begin
                        r_ram_addr <= r_ram_addr + AW'(1);
                    end
                end
            end

            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_src       <= src_base;
                        r_dst       <= dst_base;
                        r_len       <= len;
                        r_busy      <= 1'b1;
                        r_err_cnt   <= '0;
                        r_first_err <= '0;
                        if (len == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= StCopy;
                            r_rom_addr <= src_base;
                            r_iss_vld  <= 1'b1;
                            r_iss_idx  <= '0;
                        end
                    end
                end
                StCopy: begin
                    if (w_pipe_vld) begin
                        r_ram_wren <= 1'b1;
                        r_ram_addr <= r_dst + w_pipe_idx;
                        r_ram_data <= rom_q;
                        r_wr_idx   <= w_pipe_idx;
                    end
                    // Verify reads start the cycle after the final write.
                    if (r_ram_wren && w_wr_last) begin
                        r_state    <= StVerify;
                        r_rom_addr <= r_src;
                        r_ram_addr <= r_dst;
                        r_iss_vld  <= 1'b1;
                        r_iss_idx  <= '0;
                    end
                end
                StVerify: begin
                    if (w_pipe_vld) begin
                        if (rom_q != ram_q) begin
                            if (r_err_cnt != ErrMax) begin
                                r_err_cnt <= r_err_cnt + (AW+1)'(1);
                            end
                            if (r_err_cnt == '0) begin
                                r_first_err <= r_dst + w_pipe_idx;
                            end
                        end
                        if (w_pipe_last) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err;
    assign rom_addr       = r_rom_addr;
    assign ram_addr       = r_ram_addr;
    assign ram_data       = r_ram_data;
    assign ram_wren       = r_ram_wren;

endmodule
